trap_controller: RTL and testbench

- Sequences pre-trap handling for the RV32 core: on an exception or MRET it performs the required CSR writes and reads, then supplies the redirect PC.
- Drives trap_done into the control unit's pc_stall term. The stall holds from the cycle a trap is flagged until the redirect target is valid.
- Sits between the instruction decoder/exception detect logic and the CSR file. It has its own CSR access port, separate from the instruction CSR path.

---
 rtl/trap_controller_pkg.sv | 60 ++++++
 rtl/trap_controller.sv | 111 +++++++++++
 tb/tb_trap_controller.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/trap_controller_pkg.sv
// Shared trap definitions: event codes, mcause values, sequencer states, CSR addresses.
package trap_controller_pkg;

    // Event codes presented by the decoder / exception-detect logic.
    typedef enum logic [2:0] {
        TRAP_NONE             = 3'd0,
        TRAP_ECALL            = 3'd1,
        TRAP_EBREAK           = 3'd2,
        TRAP_ILLEGAL          = 3'd3,
        TRAP_MISALIGNED_FETCH = 3'd4,
        TRAP_MISALIGNED_LOAD  = 3'd5,
        TRAP_MISALIGNED_STORE = 3'd6,
        TRAP_MRET             = 3'd7
    } trap_status_e;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_W_MEPC   = 3'd1,
        ST_W_MCAUSE = 3'd2,
        ST_W_MTVAL  = 3'd3,
        ST_R_MTVEC  = 3'd4,
        ST_R_MEPC   = 3'd5,
        ST_DONE     = 3'd6
    } trap_state_e;

    localparam int unsigned CAUSE_WIDTH    = 4;
    localparam int unsigned CSR_ADDR_BITS  = 12;

    // Exception codes written to mcause (interrupt bit always clear).
    localparam logic [CAUSE_WIDTH-1:0] MCAUSE_MISALIGNED_FETCH = 4'd0;
    localparam logic [CAUSE_WIDTH-1:0] MCAUSE_ILLEGAL          = 4'd2;
    localparam logic [CAUSE_WIDTH-1:0] MCAUSE_BREAKPOINT       = 4'd3;
    localparam logic [CAUSE_WIDTH-1:0] MCAUSE_MISALIGNED_LOAD  = 4'd4;
    localparam logic [CAUSE_WIDTH-1:0] MCAUSE_MISALIGNED_STORE = 4'd6;
    localparam logic [CAUSE_WIDTH-1:0] MCAUSE_ECALL_M          = 4'd11;

    // Machine-mode trap CSR addresses.
    localparam logic [CSR_ADDR_BITS-1:0] CSR_MTVEC  = 12'h305;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_MEPC   = 12'h341;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_MCAUSE = 12'h342;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_MTVAL  = 12'h343;

    // Map an exception event to its mcause code.
    function automatic logic [CAUSE_WIDTH-1:0] cause_of(input trap_status_e s);
        logic [CAUSE_WIDTH-1:0] c;
        c = MCAUSE_MISALIGNED_FETCH;
        case (s)
            TRAP_ECALL:            c = MCAUSE_ECALL_M;
            TRAP_EBREAK:           c = MCAUSE_BREAKPOINT;
            TRAP_ILLEGAL:          c = MCAUSE_ILLEGAL;
            TRAP_MISALIGNED_FETCH: c = MCAUSE_MISALIGNED_FETCH;
            TRAP_MISALIGNED_LOAD:  c = MCAUSE_MISALIGNED_LOAD;
            TRAP_MISALIGNED_STORE: c = MCAUSE_MISALIGNED_STORE;
            default:               c = MCAUSE_MISALIGNED_FETCH;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/trap_controller.sv
// Pre-trap sequencer: writes mepc/mcause/mtval, reads mtvec (or mepc for MRET),
// then presents the redirect PC for one cycle while holding the pipeline stalled.
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned CSR_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [2:0]                trap_status,
    input  logic [XLEN-1:0]           pc,
    input  logic [XLEN-1:0]           bad_value,
    input  logic [XLEN-1:0]           csr_read_data,
    input  logic                      csr_ready,
    output logic                      trap_done,
    output logic [XLEN-1:0]           trap_target,
    output logic                      trap_redirect,
    output logic                      csr_trap_write_enable,
    output logic [CSR_ADDR_WIDTH-1:0] csr_trap_address,
    output logic [XLEN-1:0]           csr_trap_write_data
);

    trap_state_e             state;
    trap_status_e            status;
    logic [CAUSE_WIDTH-1:0]  cause_q;
    logic [XLEN-1:0]         pc_q;
    logic [XLEN-1:0]         tval_q;

    assign status = trap_status_e'(trap_status);

    // Stall term: released only when idle with nothing flagged, or when the target is valid.
    assign trap_done = ((state == ST_IDLE) && (status == TRAP_NONE)) || (state == ST_DONE);

    // Sequencer with registered CSR port and redirect outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                 <= ST_IDLE;
            trap_redirect         <= 1'b0;
            csr_trap_write_enable <= 1'b0;
            csr_trap_address      <= '0;
            csr_trap_write_data   <= '0;
            trap_target           <= '0;
            cause_q               <= '0;
            pc_q                  <= '0;
            tval_q                <= '0;
        end else begin
            trap_redirect <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (status == TRAP_MRET) begin
                        state                 <= ST_R_MEPC;
                        csr_trap_write_enable <= 1'b0;
                        csr_trap_address      <= CSR_ADDR_WIDTH'(CSR_MEPC);
                        csr_trap_write_data   <= '0;
                    end else if (status != TRAP_NONE) begin
                        state                 <= ST_W_MEPC;
                        pc_q                  <= pc;
                        cause_q               <= cause_of(status);
                        tval_q                <= (status == TRAP_ECALL) ? '0 : bad_value;
                        csr_trap_write_enable <= 1'b1;
                        csr_trap_address      <= CSR_ADDR_WIDTH'(CSR_MEPC);
                        csr_trap_write_data   <= pc;
                    end
                end
                ST_W_MEPC: begin
                    if (csr_ready) begin
                        state               <= ST_W_MCAUSE;
                        csr_trap_address    <= CSR_ADDR_WIDTH'(CSR_MCAUSE);
                        csr_trap_write_data <= XLEN'(cause_q);
                    end
                end
                ST_W_MCAUSE: begin
                    if (csr_ready) begin
                        state               <= ST_W_MTVAL;
                        csr_trap_address    <= CSR_ADDR_WIDTH'(CSR_MTVAL);
                        csr_trap_write_data <= tval_q;
                    end
                end
                ST_W_MTVAL: begin
                    if (csr_ready) begin
                        state                 <= ST_R_MTVEC;
                        csr_trap_write_enable <= 1'b0;
                        csr_trap_address      <= CSR_ADDR_WIDTH'(CSR_MTVEC);
                        csr_trap_write_data   <= '0;
                    end
                end
                ST_R_MTVEC, ST_R_MEPC: begin
                    // Direct mode only: low two bits of the read value are dropped.
                    if (csr_ready) begin
                        state               <= ST_DONE;
                        trap_target         <= csr_read_data & ~XLEN'(3);
                        trap_redirect       <= 1'b1;
                        csr_trap_address    <= '0;
                        csr_trap_write_data <= '0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state                 <= ST_IDLE;
                    csr_trap_write_enable <= 1'b0;
                    csr_trap_address      <= '0;
                    csr_trap_write_data   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller with a CSR-access / redirect scoreboard.
module tb_trap_controller;
    import trap_controller_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  trap_status;
    logic [31:0] pc;
    logic [31:0] bad_value;
    logic [31:0] csr_read_data;
    logic        csr_ready;
    logic        trap_done;
    logic [31:0] trap_target;
    logic        trap_redirect;
    logic        csr_trap_write_enable;
    logic [11:0] csr_trap_address;
    logic [31:0] csr_trap_write_data;

    trap_controller #(.XLEN(32), .CSR_ADDR_WIDTH(12)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .trap_status           (trap_status),
        .pc                    (pc),
        .bad_value             (bad_value),
        .csr_read_data         (csr_read_data),
        .csr_ready             (csr_ready),
        .trap_done             (trap_done),
        .trap_target           (trap_target),
        .trap_redirect         (trap_redirect),
        .csr_trap_write_enable (csr_trap_write_enable),
        .csr_trap_address      (csr_trap_address),
        .csr_trap_write_data   (csr_trap_write_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t        acc_q[$];
    logic [31:0] tgt_q[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int cyc0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare any accepted CSR access or redirect against the scoreboard.
    task automatic monitor();
        acc_t a;
        if (trap_redirect) begin
            if (tgt_q.size() == 0) check("redirect_unexpected", 32'(trap_redirect), 32'd0);
            else begin
                check("trap_target", trap_target, tgt_q.pop_front());
                check("done_in_redirect", 32'(trap_done), 32'd1);
            end
        end else if ((csr_trap_write_enable || csr_trap_address != 12'd0) && csr_ready) begin
            if (acc_q.size() == 0) check("access_unexpected", 32'(csr_trap_address), 32'd0);
            else begin
                a = acc_q.pop_front();
                check("acc_we",   32'(csr_trap_write_enable), 32'(a.we));
                check("acc_addr", 32'(csr_trap_address),      32'(a.addr));
                check("acc_data", csr_trap_write_data,        a.data);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_exc(input logic [31:0] p, input logic [31:0] cause,
                            input logic [31:0] tval, input logic [31:0] tgt);
        acc_q.push_back({1'b1, 12'h341, p});
        acc_q.push_back({1'b1, 12'h342, cause});
        acc_q.push_back({1'b1, 12'h343, tval});
        acc_q.push_back({1'b0, 12'h305, 32'h0});
        tgt_q.push_back(tgt);
    endtask

    task automatic wait_redirect(input int start, input int exp_lat, input string tag);
        int n_high;
        n_high = 0;
        while (trap_redirect !== 1'b1 && (cyc - start) < 40) begin
            if (trap_done !== 1'b0) n_high++;
            tick();
        end
        check({tag, "_latency"}, 32'(cyc - start), 32'(exp_lat));
        check({tag, "_done_high_early"}, 32'(n_high), 32'd0);
    endtask

    task automatic start_trap(input trap_status_e s, input logic [31:0] p, input logic [31:0] b,
                              input logic [31:0] rd, input string tag);
        trap_status   = s;
        pc            = p;
        bad_value     = b;
        csr_read_data = rd;
        #1;
        check({tag, "_done_low_flag_cycle"}, 32'(trap_done), 32'd0);
        cyc0 = cyc;
        tick();
        trap_status = TRAP_NONE;
        pc          = 32'hFFFF_FFF0;
        bad_value   = 32'h5555_5555;
    endtask

    initial begin
        reset         = 1'b1;
        trap_status   = TRAP_NONE;
        pc            = '0;
        bad_value     = '0;
        csr_read_data = '0;
        csr_ready     = 1'b1;
        #1;
        check("rst_we",       32'(csr_trap_write_enable), 32'd0);
        check("rst_addr",     32'(csr_trap_address), 32'd0);
        check("rst_target",   trap_target, 32'd0);
        check("rst_redirect", 32'(trap_redirect), 32'd0);
        check("rst_done",     32'(trap_done), 32'd1);
        tick();
        reset = 1'b0;
        tick();

        // ECALL: mtval forced to 0, mtvec low bits dropped.
        push_exc(32'h100, 32'd11, 32'h0, 32'h200);
        start_trap(TRAP_ECALL, 32'h100, 32'h1234_5678, 32'h201, "ecall");
        wait_redirect(cyc0, 5, "ecall");
        tick();
        check("ecall_idle_done", 32'(trap_done), 32'd1);

        // ILLEGAL: faulting word goes to mtval.
        push_exc(32'h200, 32'd2, 32'hDEAD_BEEF, 32'h300);
        start_trap(TRAP_ILLEGAL, 32'h200, 32'hDEAD_BEEF, 32'h300, "illegal");
        wait_redirect(cyc0, 5, "illegal");
        tick();

        // MRET: single mepc read, no writes.
        acc_q.push_back({1'b0, 12'h341, 32'h0});
        tgt_q.push_back(32'h104);
        start_trap(TRAP_MRET, 32'h0, 32'h0, 32'h104, "mret");
        check("mret_we", 32'(csr_trap_write_enable), 32'd0);
        wait_redirect(cyc0, 2, "mret");
        tick();

        // MISALIGNED_STORE with csr_ready low for 3 cycles in W_MCAUSE.
        push_exc(32'h400, 32'd6, 32'h1003, 32'h8000_0000);
        start_trap(TRAP_MISALIGNED_STORE, 32'h400, 32'h1003, 32'h8000_0003, "stall");
        tick();
        csr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_addr", 32'(csr_trap_address), 32'h342);
            check("stall_we",   32'(csr_trap_write_enable), 32'd1);
            check("stall_data", csr_trap_write_data, 32'd6);
            check("stall_done", 32'(trap_done), 32'd0);
            tick();
        end
        csr_ready = 1'b1;
        check("stall_release_addr", 32'(csr_trap_address), 32'h342);
        wait_redirect(cyc0, 8, "stall");
        tick();

        // Reset while in W_MTVAL.
        push_exc(32'h500, 32'd11, 32'h0, 32'h600);
        start_trap(TRAP_ECALL, 32'h500, 32'h0, 32'h600, "rstmid");
        tick();
        tick();
        check("rstmid_pre_addr", 32'(csr_trap_address), 32'h343);
        reset = 1'b1;
        #1;
        check("rstmid_we",       32'(csr_trap_write_enable), 32'd0);
        check("rstmid_addr",     32'(csr_trap_address), 32'd0);
        check("rstmid_data",     csr_trap_write_data, 32'd0);
        check("rstmid_target",   trap_target, 32'd0);
        check("rstmid_redirect", 32'(trap_redirect), 32'd0);
        check("rstmid_done",     32'(trap_done), 32'd1);
        acc_q.delete();
        tgt_q.delete();
        tick();
        reset = 1'b0;
        tick();

        // MISALIGNED_LOAD followed immediately by EBREAK in the IDLE cycle after DONE.
        push_exc(32'h600, 32'd4, 32'h603, 32'h1000);
        start_trap(TRAP_MISALIGNED_LOAD, 32'h600, 32'h603, 32'h1000, "b2b_load");
        wait_redirect(cyc0, 5, "b2b_load");
        push_exc(32'h700, 32'd3, 32'h700, 32'h1000);
        tick();
        start_trap(TRAP_EBREAK, 32'h700, 32'h700, 32'h1000, "b2b_ebreak");
        wait_redirect(cyc0, 5, "b2b_ebreak");
        tick();
        tick();

        check("acc_q_drained", 32'(acc_q.size()), 32'd0);
        check("tgt_q_drained", 32'(tgt_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
